// File: rtl/mac_unit.sv
// ---------------------------------------------------------------------------
// mac_unit
//   Multi-cycle multiply-accumulate unit for a custom instruction in a
//   five-stage pipeline. The multiply is a serial shift-add (one partial
//   product per cycle). The product is then added to or subtracted from a
//   private accumulator. The result and the new accumulator value then travel
//   E -> M -> W beside the instruction. The accumulator is written only when
//   the instruction commits out of Memory.
//
//   Funct3E: 000 mac (acc += A*B), 001 msub (acc -= A*B),
//            011 clracc (rd = acc, acc = 0), others rdacc (rd = acc)
//
//   Optional build macro: MAC_SATURATE_EN
//     defined   -> accumulate saturates to the signed XLEN bounds
//     undefined -> accumulate wraps modulo 2^XLEN (default)
//     The macro changes the arithmetic only, never the cycle count.
//
// Ports
//   clk                 : clock
//   reset               : synchronous, active-high reset
//   StallE/M/W          : hazard-unit stage stalls
//   FlushE/M/W          : hazard-unit stage flushes
//   MacValidE           : a MAC-class instruction is in Execute
//   Funct3E[2:0]        : operation select
//   ForwardedSrcAE/BE   : forwarded operands, captured on the start cycle
//   MacStallE           : hold Execute while the unit is busy or interlocked
//   MacValidW           : a MAC result is in Writeback
//   MacResultW          : register-file write value
// ---------------------------------------------------------------------------
module mac_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic            StallM,
  input  logic            FlushM,
  input  logic            StallW,
  input  logic            FlushW,
  input  logic            MacValidE,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] ForwardedSrcAE,
  input  logic [XLEN-1:0] ForwardedSrcBE,
  output logic            MacStallE,
  output logic            MacValidW,
  output logic [XLEN-1:0] MacResultW
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_prod;
  logic            r_sub;
  logic [XLEN-1:0] r_res_e;   // result == new accumulator for mac/msub
  logic [XLEN-1:0] r_acc;

  logic            r_valid_m;
  logic [XLEN-1:0] r_res_m;
  logic [XLEN-1:0] r_nacc_m;
  logic            r_valid_w;
  logic [XLEN-1:0] r_res_w;

  logic            w_is_mul;
  logic            w_is_clr;
  logic            w_start;
  logic            w_step;
  logic            w_acc_calc;
  logic            w_done_e;
  logic            w_stall;
  logic            w_commit_m;
  logic [XLEN-1:0] w_res_e;
  logic [XLEN-1:0] w_nacc_e;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_newacc;

  assign w_is_mul = (Funct3E == 3'b000) || (Funct3E == 3'b001);
  assign w_is_clr = (Funct3E == 3'b011);

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_step       = 1'b0;
    w_acc_calc   = 1'b0;
    w_done_e     = 1'b0;
    w_stall      = 1'b0;
    case (r_state)
      IDLE: begin
        // A flushed instruction never starts, even if MacValidE is high.
        if (MacValidE && !FlushE) begin
          if (w_is_mul) begin
            w_start      = 1'b1;
            w_stall      = 1'b1;
            w_state_next = MUL;
          end else if (r_valid_m) begin
            // rdacc/clracc must see the accumulator after the op in M commits
            w_stall = 1'b1;
          end else if (!StallE) begin
            w_done_e = 1'b1;
          end
        end
      end
      MUL: begin
        w_stall = 1'b1;
        if (FlushE) begin
          w_state_next = IDLE;
        end else begin
          w_step = 1'b1;
          if (r_cnt == CW'(XLEN - 1)) w_state_next = ACC;
        end
      end
      ACC: begin
        w_stall = 1'b1;
        if (FlushE) begin
          w_state_next = IDLE;
        end else if (!r_valid_m) begin
          w_acc_calc   = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (FlushE) begin
          w_state_next = IDLE;
        end else if (!StallE) begin
          w_done_e     = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign MacStallE = w_stall & ~reset;

  // -------------------------------------------------------------------------
  // Accumulate arithmetic
  // -------------------------------------------------------------------------
  assign w_sum = r_sub ? (r_acc - r_prod) : (r_acc + r_prod);

`ifdef MAC_SATURATE_EN
  localparam logic [XLEN-1:0] SMAX = {1'b0, {(XLEN-1){1'b1}}};
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
  logic w_ovf;
  // Overflow: operands effectively share a sign but the result sign differs.
  assign w_ovf = (r_sub ? (r_acc[XLEN-1] != r_prod[XLEN-1])
                        : (r_acc[XLEN-1] == r_prod[XLEN-1]))
                 && (w_sum[XLEN-1] != r_acc[XLEN-1]);
  assign w_newacc = w_ovf ? (r_acc[XLEN-1] ? SMIN : SMAX) : w_sum;
`else
  assign w_newacc = w_sum;
`endif

  // -------------------------------------------------------------------------
  // Serial multiplier and Execute result
  //   Operands are copied on the start cycle, so later changes on the
  //   forwarding inputs cannot disturb a running multiply.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
      r_sub   <= 1'b0;
      r_res_e <= '0;
    end else begin
      if (w_start) begin
        r_a    <= ForwardedSrcAE;
        r_b    <= ForwardedSrcBE;
        r_prod <= '0;
        r_cnt  <= '0;
        r_sub  <= (Funct3E == 3'b001);
      end else if (w_step) begin
        if (r_b[0]) r_prod <= r_prod + r_a;
        r_a   <= r_a << 1;
        r_b   <= r_b >> 1;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_acc_calc) r_res_e <= w_newacc;
    end
  end

  // In DONE the mac/msub result is presented. In IDLE the single-cycle
  // rdacc/clracc result is the live accumulator.
  assign w_res_e  = (r_state == DONE) ? r_res_e : r_acc;
  assign w_nacc_e = (r_state == DONE) ? r_res_e : (w_is_clr ? '0 : r_acc);

  // -------------------------------------------------------------------------
  // Memory stage, accumulator commit, Writeback stage
  // -------------------------------------------------------------------------
  assign w_commit_m = r_valid_m & ~StallM & ~FlushM;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_m <= 1'b0;
      r_res_m   <= '0;
      r_nacc_m  <= '0;
      r_acc     <= '0;
      r_valid_w <= 1'b0;
      r_res_w   <= '0;
    end else begin
      if (FlushM) begin
        r_valid_m <= 1'b0;
      end else if (!StallM) begin
        r_valid_m <= w_done_e;
        r_res_m   <= w_res_e;
        r_nacc_m  <= w_nacc_e;
      end

      if (w_commit_m) r_acc <= r_nacc_m;

      if (FlushW) begin
        r_valid_w <= 1'b0;
      end else if (!StallW) begin
        // A stalled M stage sends a bubble into W.
        r_valid_w <= w_commit_m;
        if (w_commit_m) r_res_w <= r_res_m;
      end
    end
  end

  assign MacValidW  = r_valid_w;
  assign MacResultW = r_res_w;

endmodule

// File: tb/tb_mac_unit.sv
// ---------------------------------------------------------------------------
// tb_mac_unit
//   Directed scoreboard bench for mac_unit (XLEN = 64). Each issued operation
//   that should reach Writeback pushes its hand-computed result into a
//   queue. An independent monitor pops and compares every MacValidW pulse.
//   An unexpected pulse (e.g. from a flushed or reset operation) is an error.
// ---------------------------------------------------------------------------
module tb_mac_unit;

  localparam int XLEN = 64;
  localparam logic [2:0] OP_MAC  = 3'b000;
  localparam logic [2:0] OP_MSUB = 3'b001;
  localparam logic [2:0] OP_RD   = 3'b010;
  localparam logic [2:0] OP_CLR  = 3'b011;
  localparam logic [XLEN-1:0] SMAX = 64'h7FFF_FFFF_FFFF_FFFF;
`ifdef MAC_SATURATE_EN
  localparam logic [XLEN-1:0] OVF_EXP = 64'h7FFF_FFFF_FFFF_FFFF;
`else
  localparam logic [XLEN-1:0] OVF_EXP = 64'h8000_0000_0000_0000;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            StallE, FlushE, StallM, FlushM, StallW, FlushW;
  logic            MacValidE;
  logic [2:0]      Funct3E;
  logic [XLEN-1:0] ForwardedSrcAE, ForwardedSrcBE;
  logic            MacStallE;
  logic            MacValidW;
  logic [XLEN-1:0] MacResultW;

  int n_pass  = 0;
  int n_total = 0;
  logic [XLEN-1:0] exp_q[$];

  mac_unit #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .reset          (reset),
    .StallE         (StallE),
    .FlushE         (FlushE),
    .StallM         (StallM),
    .FlushM         (FlushM),
    .StallW         (StallW),
    .FlushW         (FlushW),
    .MacValidE      (MacValidE),
    .Funct3E        (Funct3E),
    .ForwardedSrcAE (ForwardedSrcAE),
    .ForwardedSrcBE (ForwardedSrcBE),
    .MacStallE      (MacStallE),
    .MacValidW      (MacValidW),
    .MacResultW     (MacResultW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    else begin
      n_pass++;
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: every Writeback pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (MacValidW) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_wb: MacValidW=1 result %h, expected no result", MacResultW);
      end else begin
        chk("wb_result", MacResultW, exp_q.pop_front());
      end
    end
  end

  // Issue one instruction from the current negedge. Holds it in Execute while
  // MacStallE is high, scrambling the operand inputs after the capture cycle.
  // Returns at the negedge after the instruction has left Execute.
  task automatic issue(input logic [2:0] f3, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input bit push,
                       input logic [XLEN-1:0] exp, output int stalls);
    MacValidE      = 1'b1;
    Funct3E        = f3;
    ForwardedSrcAE = a;
    ForwardedSrcBE = b;
    stalls         = 0;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (!MacStallE) break;
      stalls++;
      @(negedge clk);
      ForwardedSrcAE = {$urandom, $urandom};
      ForwardedSrcBE = {$urandom, $urandom};
    end
    if (MacStallE) begin
      n_total++;
      $display("FAIL issue_timeout: MacStallE still 1 after 300 cycles, expected 0");
    end
    $display("issue f3=%b a=%h b=%h stalls=%0d", f3, a, b, stalls);
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    MacValidE = 1'b0;
    Funct3E   = 3'b000;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    reset = 1'b1;
    {StallE, FlushE, StallM, FlushM, StallW, FlushW} = '0;
    MacValidE = 1'b0; Funct3E = 3'b000;
    ForwardedSrcAE = '0; ForwardedSrcBE = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_stall",  {63'd0, MacStallE}, 64'd0);
    chk("rst_validw", {63'd0, MacValidW}, 64'd0);
    chk("rst_result", MacResultW, 64'd0);

    // mac 3*5 -> 15, XLEN+2 stall cycles
    issue(OP_MAC, 64'd3, 64'd5, 1'b1, 64'd15, s);
    chk("mac_stall_cycles", 64'(s), 64'(XLEN + 2));
    // msub -2*4 -> 15 - (-8) = 23
    issue(OP_MSUB, 64'hFFFF_FFFF_FFFF_FFFE, 64'd4, 1'b1, 64'd23, s);
    // clracc right behind msub: one interlock cycle while msub is in M
    issue(OP_CLR, 64'd0, 64'd0, 1'b1, 64'd23, s);
    chk("clracc_m_interlock", 64'(s), 64'd1);
    repeat (3) @(negedge clk);
    issue(OP_RD, 64'd0, 64'd0, 1'b1, 64'd0, s);
    chk("rdacc_no_stall", 64'(s), 64'd0);

    // Back-to-back: first held in M long enough that the second waits in ACC.
    issue(OP_MAC, 64'd2, 64'd3, 1'b1, 64'd6, s);
    StallM = 1'b1;
    fork
      issue(OP_MAC, 64'd4, 64'd5, 1'b1, 64'd26, s);
      begin
        repeat (XLEN + 6) @(negedge clk);
        StallM = 1'b0;
      end
    join
    chk("b2b_acc_wait", {63'd0, (s > XLEN + 2)}, 64'd1);
    issue(OP_RD, 64'd0, 64'd0, 1'b1, 64'd26, s);

    // FlushE on MUL cycle 10 of mac 7*7
    MacValidE = 1'b1; Funct3E = OP_MAC;
    ForwardedSrcAE = 64'd7; ForwardedSrcBE = 64'd7;
    repeat (10) @(negedge clk);
    FlushE = 1'b1; MacValidE = 1'b0;
    @(negedge clk);
    FlushE = 1'b0;
    #1 chk("flushE_back_to_idle", {63'd0, MacStallE}, 64'd0);
    @(negedge clk);
    repeat (4) @(negedge clk);
    issue(OP_RD, 64'd0, 64'd0, 1'b1, 64'd26, s);

    // New MacValidE together with FlushE is ignored
    MacValidE = 1'b1; Funct3E = OP_MAC; FlushE = 1'b1;
    #1 chk("flushE_start_cycle", {63'd0, MacStallE}, 64'd0);
    @(negedge clk);
    MacValidE = 1'b0; FlushE = 1'b0;
    #1 chk("flushE_no_start", {63'd0, MacStallE}, 64'd0);
    @(negedge clk);

    // mac killed by FlushM while in Memory
    issue(OP_MAC, 64'd3, 64'd3, 1'b0, 64'd0, s);
    FlushM = 1'b1;
    @(negedge clk);
    FlushM = 1'b0;
    issue(OP_RD, 64'd0, 64'd0, 1'b1, 64'd26, s);

    // Overflow boundary: acc = max positive, then + 1*1
    issue(OP_CLR, 64'd0, 64'd0, 1'b1, 64'd26, s);
    issue(OP_MAC, SMAX, 64'd1, 1'b1, SMAX, s);
    issue(OP_MAC, 64'd1, 64'd1, 1'b1, OVF_EXP, s);
    issue(OP_RD, 64'd0, 64'd0, 1'b1, OVF_EXP, s);

    // Reset during MUL aborts the operation and clears the accumulator
    MacValidE = 1'b1; Funct3E = OP_MAC;
    ForwardedSrcAE = 64'd5; ForwardedSrcBE = 64'd5;
    repeat (20) @(negedge clk);
    reset = 1'b1; MacValidE = 1'b0;
    #1 chk("reset_mid_stall", {63'd0, MacStallE}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_mid_result", MacResultW, 64'd0);
    repeat (70) @(negedge clk);
    issue(OP_RD, 64'd0, 64'd0, 1'b1, 64'd0, s);

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
